ifetch_ctrl: RTL and testbench

//  Sequences instruction-bus transactions for the fetch stage.
//  - Takes the current PC, issues one ibus request, and holds it until data_ok.
//  - Registers the returned instruction and delivers it downstream with a valid/stall handshake.
//  - Handles redirect (flush) while a transaction is in flight by draining and discarding it.
//  - Sits between the PC register and the fetch/decode pipeline register.

---
 rtl/pipes_pkg.sv | 41 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/ifetch_ctrl.sv | 108 ++++++++++
 tb/tb_ifetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipes_pkg.sv
// Shared fetch-stage types: bus request/response, exception codes, fetch FSM
// states and the fetch output bundle reused by the decode pipeline register.
package pipes_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] instr_t;

  typedef enum logic {
    NOEX       = 1'b0,
    INSTR_ADDR = 1'b1
  } exception_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic   addr_ok;
    logic   data_ok;
    instr_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic       valid;
    instr_t     instr;
    addr_t      pc;
    exception_t ex;
  } fetch_out_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance statistics; clr wins over inc and the
// count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage bus sequencer: one ibus transaction per PC, registered result
// handed downstream with a valid/stall handshake, redirects drain in-flight reads.
module ifetch_ctrl
  import pipes_pkg::*;
#(
  parameter int XLEN  = pipes_pkg::XLEN,
  parameter int ILEN  = pipes_pkg::ILEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fetch_en,
  input  logic [XLEN-1:0]  pc,
  input  logic             stall,
  input  logic             flush,
  output ibus_req_t        ireq,
  input  ibus_resp_t       iresp,
  output logic             out_valid,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output exception_t       out_ex,
  output logic             pc_advance,
  output logic [CNT_W-1:0] wait_cycles,
  output fetch_state_t     dbg_state_o
);

  // Handshake: out_valid marks a registered result; downstream consumes it in a
  // cycle where stall=0, signalled back to the PC register by pc_advance.
  fetch_state_t state_q, state_d;
  addr_t        req_addr_q, req_addr_d;
  fetch_out_t   out_q, out_d;
  logic         unused_addr_ok;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && fetch_en) begin
          if (pc[1:0] == 2'b00) begin
            req_addr_d = pc;
            state_d    = REQ;
          end else begin
            out_d.instr = '0;
            out_d.pc    = pc;
            out_d.ex    = INSTR_ADDR;
            state_d     = OUT;
          end
        end
      end
      REQ: begin
        if (flush) begin
          state_d = iresp.data_ok ? IDLE : DROP;
        end else if (iresp.data_ok) begin
          out_d.instr = iresp.data;
          out_d.pc    = req_addr_q;
          out_d.ex    = NOEX;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (flush || !stall) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        // The bus cannot abort, so keep the request up until the stale data returns.
        if (iresp.data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_d.valid = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      out_q      <= '{valid: 1'b0, instr: '0, pc: '0, ex: NOEX};
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .inc_i ((state_q == REQ) || (state_q == DROP)),
    .clr_i (1'b0),
    .q_o   (wait_cycles)
  );

  assign ireq.valid     = (state_q == REQ) || (state_q == DROP);
  assign ireq.addr      = req_addr_q;
  assign out_valid      = out_q.valid;
  assign out_instr      = out_q.instr;
  assign out_pc         = out_q.pc;
  assign out_ex         = out_q.ex;
  assign pc_advance     = (state_q == OUT) && !stall && !flush;
  assign dbg_state_o    = state_q;
  assign unused_addr_ok = iresp.addr_ok;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: a driver issues fetches and pushes the
// expected deliveries; a monitor checks every presented output against them.
module tb_ifetch_ctrl;
  import pipes_pkg::*;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EW      = 1 + XLEN + ILEN;

  logic             clk;
  logic             resetn;
  logic             fetch_en;
  logic [XLEN-1:0]  pc;
  logic             stall;
  logic             flush;
  ibus_req_t        ireq;
  ibus_resp_t       iresp;
  logic             out_valid;
  logic [ILEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_pc;
  exception_t       out_ex;
  logic             pc_advance;
  logic [CNT_W-1:0] wait_cycles;
  fetch_state_t     dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            wait_exp = 0;

  ifetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .stall       (stall),
    .flush       (flush),
    .ireq        (ireq),
    .iresp       (iresp),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ex      (out_ex),
    .pc_advance  (pc_advance),
    .wait_cycles (wait_cycles),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples at the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_out(input int s_cycles, input bit flush_out);
    for (int s = 0; s < s_cycles; s++) begin
      stall = 1'b1;
      step();
    end
    if (flush_out) begin
      flush = 1'b1;
      stall = 1'($urandom_range(0, 1));
    end else begin
      stall = 1'b0;
    end
    step();
    flush = 1'b0;
    stall = 1'b0;
  endtask

  // lat = REQ cycles before the data_ok cycle; flush_at = REQ/DROP cycle index carrying flush (-1 none).
  task automatic do_aligned(input logic [XLEN-1:0] p, input logic [ILEN-1:0] d, input int lat,
                            input int flush_at, input int s_cycles, input bit flush_out);
    bit killed;
    step();
    fetch_en = 1'b1;
    pc       = p;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      chk("ireq_valid", 128'(ireq.valid), 128'(1'b1));
      chk("ireq_addr", 128'(ireq.addr), 128'(p));
      iresp.addr_ok = 1'($urandom_range(0, 1));
      iresp.data_ok = (i == lat);
      iresp.data    = (i == lat) ? d : ILEN'($urandom);
      flush         = (i == flush_at);
      step();
    end
    iresp.data_ok = 1'b0;
    flush         = 1'b0;
    wait_exp      = sat_add(wait_exp, lat + 1);
    killed        = (flush_at >= 0) && (flush_at <= lat);
    if (!killed) begin
      exp_q.push_back({1'b0, p, d});
      do_out(s_cycles, flush_out);
    end
    chk("idle_ireq_valid", 128'(ireq.valid), 128'(1'b0));
    chk("wait_cycles", 128'(wait_cycles), 128'(wait_exp));
  endtask

  task automatic do_misaligned(input logic [XLEN-1:0] p, input int s_cycles, input bit flush_out);
    step();
    fetch_en = 1'b1;
    pc       = p;
    step();
    fetch_en = 1'b0;
    chk("mis_ireq_valid", 128'(ireq.valid), 128'(1'b0));
    exp_q.push_back({1'b1, p, {ILEN{1'b0}}});
    do_out(s_cycles, flush_out);
    chk("mis_wait_cycles", 128'(wait_cycles), 128'(wait_exp));
  endtask

  task automatic do_idle_flush();
    step();
    fetch_en = 1'b1;
    flush    = 1'b1;
    pc       = XLEN'({$urandom, $urandom});
    step();
    fetch_en = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_ireq", 128'(ireq.valid), 128'(1'b0));
    chk("idle_flush_valid", 128'(out_valid), 128'(1'b0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: out_pc %0h with empty expected queue at %0t", out_pc, $time);
        end else begin
          chk("out_bundle", 128'({out_ex, out_pc, out_instr}), 128'(exp_q[0]));
          chk("pc_advance", 128'(pc_advance), 128'(!stall && !flush));
          if (flush || !stall) void'(exp_q.pop_front());
        end
      end else begin
        chk("pc_advance_idle", 128'(pc_advance), 128'(1'b0));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] rp;
    int              lat;
    int              fat;
    resetn   = 1'b0;
    fetch_en = 1'b0;
    pc       = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    iresp    = '0;
    #12;
    chk("rst_ireq_valid", 128'(ireq.valid), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_wait", 128'(wait_cycles), 128'(0));
    resetn = 1'b1;

    // Directed cases
    do_aligned(64'h8000_0000, 32'h0000_0013, 0, -1, 0, 1'b0);
    do_misaligned(64'h8000_0002, 0, 1'b0);
    do_aligned(64'h8000_0004, 32'hdead_beef, 4, -1, 0, 1'b0);
    do_aligned(64'h8000_0008, 32'h1234_5678, 5, 2, 0, 1'b0);
    do_aligned(64'h8000_000c, 32'hcafe_f00d, 1, -1, 4, 1'b0);
    do_aligned(64'h8000_0010, 32'h0bad_c0de, 2, -1, 1, 1'b1);
    do_idle_flush();

    // Asynchronous reset while a request is outstanding
    step();
    fetch_en = 1'b1;
    pc       = 64'h8000_0020;
    step();
    fetch_en = 1'b0;
    step();
    #1 resetn = 1'b0;
    #1;
    chk("arst_ireq", 128'({ireq.valid, ireq.addr}), 128'(0));
    chk("arst_out", 128'({out_valid, out_ex, out_pc, out_instr}), 128'(0));
    chk("arst_misc", 128'({pc_advance, wait_cycles}), 128'(0));
    step();
    resetn   = 1'b1;
    wait_exp = 0;
    exp_q.delete();
    step();
    chk("post_rst_ireq", 128'(ireq.valid), 128'(1'b0));

    // Randomized fetch stream; long bus waits drive the counter into saturation
    for (int n = 0; n < 80; n++) begin
      rp = XLEN'({$urandom, $urandom});
      if ($urandom_range(0, 9) == 0) begin
        do_idle_flush();
      end else if ($urandom_range(0, 6) == 0) begin
        rp[1:0] = 2'($urandom_range(1, 3));
        do_misaligned(rp, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      end else begin
        rp[1:0] = 2'b00;
        lat = $urandom_range(0, 6);
        fat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 1) : -1;
        do_aligned(rp, ILEN'($urandom), lat, fat, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      end
    end

    step();
    step();
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
